burst_echo_receiver: RTL and testbench

Receive-side counterpart to the 40 kHz transducer drive logic. It takes the digitised comparator output of a receiving transducer and a start pulse from the transmit side. It detects a valid 40 kHz echo burst by qualifying consecutive edge-to-edge periods, then reports the time-of-flight in CLK cycles. It sits beside the PWM/transducer-select logic on the 50 MHz CLK domain.

---
 rtl/burst_echo_receiver.sv | 183 ++++++++++++++++++
 tb/tb_burst_echo_receiver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/burst_echo_receiver.sv
// Receive-side echo detector: qualifies a 40 kHz burst by consecutive
// edge-to-edge periods and reports time-of-flight in clock cycles.
module burst_echo_receiver #(
    parameter int PERIOD_NOM     = 1250,
    parameter int PERIOD_TOL     = 63,
    parameter int LOCK_CYCLES    = 8,
    parameter int BLANK_CYCLES   = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TOF_W          = 20
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             rx_in_i,
    input  logic             tx_start_i,
    output logic             busy_o,
    output logic             rx_lock_o,
    output logic             tof_valid_o,
    output logic [TOF_W-1:0] tof_o,
    output logic             timeout_o,
    output logic [10:0]      period_last_o
);

    localparam logic [11:0]      PER_MIN     = 12'(PERIOD_NOM - PERIOD_TOL);
    localparam logic [11:0]      PER_MAX     = 12'(PERIOD_NOM + PERIOD_TOL);
    localparam logic [3:0]       LOCK_N      = 4'(LOCK_CYCLES);
    localparam logic [TOF_W-1:0] BLANK_END   = TOF_W'(BLANK_CYCLES - 1);
    localparam logic [TOF_W-1:0] TIMEOUT_END = TOF_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TOF_W-1:0] TOF_MAX     = '1;

    typedef enum logic [1:0] {IDLE, BLANK, LISTEN} state_e;

    state_e           state_q, state_d;
    logic             s1_q, s2_q, dly_q;
    logic [10:0]      per_cnt_q, per_cnt_d;
    logic [10:0]      period_last_q, period_last_d;
    logic             first_q, first_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [TOF_W-1:0] tof_cnt_q, tof_cnt_d;
    logic [TOF_W-1:0] edge_tof_q, edge_tof_d;
    logic [TOF_W-1:0] run_start_q, run_start_d;
    logic [TOF_W-1:0] tof_q, tof_d;
    logic             tof_valid_q, tof_valid_d;
    logic             timeout_q, timeout_d;

    logic             rx_edge;
    logic             per_good;
    logic             sig_lost;
    logic             qual_en;
    logic [11:0]      period_w;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            dly_q <= 1'b0;
        end else begin
            s1_q  <= rx_in_i;
            s2_q  <= s1_q;
            dly_q <= s2_q;
        end
    end

    // 12-bit period so a saturated counter plus one cannot wrap into range
    assign rx_edge  = s2_q & ~dly_q;
    assign period_w = {1'b0, per_cnt_q} + 12'd1;
    assign per_good = ~first_q & (period_w >= PER_MIN) & (period_w <= PER_MAX);
    assign sig_lost = ~rx_edge & ({1'b0, per_cnt_q} > PER_MAX);
    assign qual_en  = (state_q != BLANK);

    always_comb begin
        per_cnt_d     = per_cnt_q;
        period_last_d = period_last_q;
        edge_tof_d    = edge_tof_q;
        if (rx_edge) begin
            per_cnt_d     = '0;
            period_last_d = period_w[11] ? 11'h7FF : period_w[10:0];
            edge_tof_d    = tof_cnt_q;
        end else if (per_cnt_q != 11'h7FF) begin
            per_cnt_d = per_cnt_q + 11'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        tof_cnt_d   = tof_cnt_q;
        first_d     = first_q;
        good_cnt_d  = good_cnt_q;
        run_start_d = run_start_q;
        tof_d       = tof_q;
        tof_valid_d = 1'b0;
        timeout_d   = 1'b0;

        // Qualification is frozen while blanking so crosstalk cannot seed a run
        if (qual_en) begin
            if (rx_edge) begin
                first_d = 1'b0;
                if (per_good) begin
                    if (good_cnt_q != LOCK_N) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                    end
                    if (good_cnt_q == 4'd0) begin
                        run_start_d = edge_tof_q;
                    end
                end else begin
                    good_cnt_d = '0;
                end
            end else if (sig_lost) begin
                good_cnt_d = '0;
                first_d    = 1'b1;
            end
        end

        if (state_q != IDLE && tof_cnt_q != TOF_MAX) begin
            tof_cnt_d = tof_cnt_q + 1'b1;
        end

        case (state_q)
            BLANK: begin
                if (tof_cnt_q == BLANK_END) begin
                    state_d = LISTEN;
                end
            end
            LISTEN: begin
                if (good_cnt_q == LOCK_N) begin
                    tof_d       = run_start_q;
                    tof_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (tof_cnt_q == TIMEOUT_END) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        // A new transmit start always wins and drops any result of this cycle
        if (tx_start_i) begin
            state_d     = BLANK;
            tof_cnt_d   = '0;
            good_cnt_d  = '0;
            first_d     = 1'b1;
            tof_d       = tof_q;
            tof_valid_d = 1'b0;
            timeout_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            per_cnt_q     <= '0;
            period_last_q <= '0;
            first_q       <= 1'b1;
            good_cnt_q    <= '0;
            tof_cnt_q     <= '0;
            edge_tof_q    <= '0;
            run_start_q   <= '0;
            tof_q         <= '0;
            tof_valid_q   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            per_cnt_q     <= per_cnt_d;
            period_last_q <= period_last_d;
            first_q       <= first_d;
            good_cnt_q    <= good_cnt_d;
            tof_cnt_q     <= tof_cnt_d;
            edge_tof_q    <= edge_tof_d;
            run_start_q   <= run_start_d;
            tof_q         <= tof_d;
            tof_valid_q   <= tof_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign rx_lock_o     = (good_cnt_q == LOCK_N);
    assign tof_valid_o   = tof_valid_q;
    assign timeout_o     = timeout_q;
    assign tof_o         = tof_q;
    assign period_last_o = period_last_q;

endmodule

// File: tb/tb_burst_echo_receiver.sv
// Directed bench for burst_echo_receiver; timing parameters are scaled by
// roughly 1/10 (period 125 cycles) so the whole sequence stays short.
module tb_burst_echo_receiver;

    localparam int NOM   = 125;
    localparam int TOL   = 6;
    localparam int LOCKN = 8;
    localparam int BLANK = 1500;
    localparam int TMO   = 20000;
    localparam int TW    = 20;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          rxIn = 1'b0;
    logic          txStart = 1'b0;
    logic          busy, rxLock, tofValid, timeoutP;
    logic [TW-1:0] tof;
    logic [10:0]   periodLast;

    int total = 0;
    int bad = 0;
    int validCnt = 0;
    int timeoutCnt = 0;
    int bothCnt = 0;
    logic        validBusy = 1'b1;
    logic        validLock = 1'b0;
    logic [10:0] validPeriod = '0;

    burst_echo_receiver #(
        .PERIOD_NOM(NOM), .PERIOD_TOL(TOL), .LOCK_CYCLES(LOCKN),
        .BLANK_CYCLES(BLANK), .TIMEOUT_CYCLES(TMO), .TOF_W(TW)
    ) dut (
        .clk_i(clk), .rst_n_i(rstN), .rx_in_i(rxIn), .tx_start_i(txStart),
        .busy_o(busy), .rx_lock_o(rxLock), .tof_valid_o(tofValid),
        .tof_o(tof), .timeout_o(timeoutP), .period_last_o(periodLast)
    );

    always #10 clk = ~clk;

    // Pulse monitor samples on the falling edge, away from register updates
    always @(negedge clk) begin
        if (tofValid) begin
            validCnt++;
            validBusy   = busy;
            validLock   = rxLock;
            validPeriod = periodLast;
        end
        if (timeoutP) timeoutCnt++;
        if (tofValid && timeoutP) bothCnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyIdle(input int n);
        repeat (n) tick();
    endtask

    // Square wave: a rising edge at the start of every period
    task automatic applyStimulus(input int periodLen, input int count);
        for (int p = 0; p < count; p++) begin
            rxIn = 1'b1;
            applyIdle(periodLen / 2);
            rxIn = 1'b0;
            applyIdle(periodLen - periodLen / 2);
        end
    endtask

    task automatic pulseStart();
        txStart = 1'b1;
        tick();
        txStart = 1'b0;
    endtask

    task automatic checkTofWindow(input string name, input int want);
        int got;
        got = int'(tof);
        total++;
        if (got < want - 3 || got > want + 3) begin
            bad++;
            $display("[TB] FAIL %s: tof=%0d required %0d +/-3", name, got, want);
        end
    endtask

    task automatic test_reset();
        int vb, tb;
        rstN = 1'b0;
        applyIdle(5);
        rstN = 1'b1;
        tick();
        total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        total++; if (rxLock !== 1'b0)    begin bad++; $display("[TB] FAIL rst_lock: got %b want 0", rxLock); end
        total++; if (tofValid !== 1'b0)  begin bad++; $display("[TB] FAIL rst_valid: got %b want 0", tofValid); end
        total++; if (timeoutP !== 1'b0)  begin bad++; $display("[TB] FAIL rst_timeout: got %b want 0", timeoutP); end
        total++; if (tof !== '0)         begin bad++; $display("[TB] FAIL rst_tof: got %0d want 0", tof); end
        total++; if (periodLast !== '0)  begin bad++; $display("[TB] FAIL rst_period: got %0d want 0", periodLast); end
        vb = validCnt; tb = timeoutCnt;
        applyIdle(5000);
        total++; if (validCnt - vb != 0)   begin bad++; $display("[TB] FAIL idle_valid: got %0d pulses want 0", validCnt - vb); end
        total++; if (timeoutCnt - tb != 0) begin bad++; $display("[TB] FAIL idle_timeout: got %0d pulses want 0", timeoutCnt - tb); end
        total++; if (busy !== 1'b0)        begin bad++; $display("[TB] FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic_echo();
        int vb, tb;
        pulseStart();
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy: got %b want 1", busy); end
        applyIdle(8000);
        vb = validCnt; tb = timeoutCnt;
        applyStimulus(NOM, 12);
        total++; if (validCnt - vb != 1)   begin bad++; $display("[TB] FAIL basic_valid_count: got %0d want 1", validCnt - vb); end
        checkTofWindow("basic_tof", 8000);
        total++; if (validLock !== 1'b1)   begin bad++; $display("[TB] FAIL basic_lock_at_valid: got %b want 1", validLock); end
        total++; if (validPeriod !== 11'd125) begin bad++; $display("[TB] FAIL basic_period: got %0d want 125", validPeriod); end
        total++; if (validBusy !== 1'b0)   begin bad++; $display("[TB] FAIL basic_busy_at_valid: got %b want 0", validBusy); end
        total++; if (rxLock !== 1'b1)      begin bad++; $display("[TB] FAIL basic_lock_hold: got %b want 1", rxLock); end
        total++; if (timeoutCnt - tb != 0) begin bad++; $display("[TB] FAIL basic_timeout: got %0d want 0", timeoutCnt - tb); end
        applyIdle(300);
        total++; if (rxLock !== 1'b0)      begin bad++; $display("[TB] FAIL basic_lock_lost: got %b want 0", rxLock); end
    endtask

    task automatic test_blanking();
        int vb;
        pulseStart();
        vb = validCnt;
        applyIdle(250);
        applyStimulus(NOM, 10);
        applyIdle(4500);
        total++; if (validCnt - vb != 0) begin bad++; $display("[TB] FAIL blank_early_valid: got %0d want 0", validCnt - vb); end
        applyStimulus(NOM, 12);
        total++; if (validCnt - vb != 1) begin bad++; $display("[TB] FAIL blank_valid_count: got %0d want 1", validCnt - vb); end
        checkTofWindow("blank_tof", 6000);
        applyIdle(300);
    endtask

    task automatic test_timeout();
        int vb, n;
        bit seen;
        vb = validCnt; n = 0; seen = 1'b0;
        pulseStart();
        for (int i = 0; i < TMO + 200; i++) begin
            tick();
            n++;
            if (timeoutP) begin seen = 1'b1; break; end
        end
        total++; if (!seen)   begin bad++; $display("[TB] FAIL tmo_seen: got none want pulse within %0d", TMO + 200); end
        total++; if (n != TMO) begin bad++; $display("[TB] FAIL tmo_cycle: got %0d want %0d", n, TMO); end
        total++; if (tofValid !== 1'b0) begin bad++; $display("[TB] FAIL tmo_valid_with: got %b want 0", tofValid); end
        tick();
        total++; if (timeoutP !== 1'b0) begin bad++; $display("[TB] FAIL tmo_width: got %b want 0", timeoutP); end
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL tmo_busy: got %b want 0", busy); end
        total++; if (validCnt - vb != 0) begin bad++; $display("[TB] FAIL tmo_valid: got %0d want 0", validCnt - vb); end
        checkTofWindow("tmo_tof_kept", 6000);
    endtask

    task automatic test_period_qual();
        int vb;
        pulseStart();
        applyIdle(2000);
        vb = validCnt;
        applyStimulus(140, 4);
        total++; if (validCnt - vb != 0) begin bad++; $display("[TB] FAIL qual_140_valid: got %0d want 0", validCnt - vb); end
        total++; if (rxLock !== 1'b0)    begin bad++; $display("[TB] FAIL qual_140_lock: got %b want 0", rxLock); end
        applyStimulus(130, 10);
        total++; if (validCnt - vb != 1) begin bad++; $display("[TB] FAIL qual_130_valid: got %0d want 1", validCnt - vb); end
        checkTofWindow("qual_130_tof", 2560);
        total++; if (validPeriod !== 11'd130) begin bad++; $display("[TB] FAIL qual_130_period: got %0d want 130", validPeriod); end
        applyIdle(300);
        total++; if (rxLock !== 1'b0)    begin bad++; $display("[TB] FAIL qual_lock_drop: got %b want 0", rxLock); end

        pulseStart();
        applyIdle(2000);
        vb = validCnt;
        applyStimulus(NOM, 5);
        applyStimulus(90, 1);
        applyStimulus(NOM, 4);
        total++; if (validCnt - vb != 0) begin bad++; $display("[TB] FAIL gap_valid: got %0d want 0", validCnt - vb); end
        total++; if (rxLock !== 1'b0)    begin bad++; $display("[TB] FAIL gap_lock: got %b want 0", rxLock); end
        total++; if (periodLast !== 11'd125) begin bad++; $display("[TB] FAIL gap_period: got %0d want 125", periodLast); end
        applyStimulus(NOM, 7);
        total++; if (validCnt - vb != 1) begin bad++; $display("[TB] FAIL gap_relock_valid: got %0d want 1", validCnt - vb); end
        checkTofWindow("gap_tof", 2715);
        applyIdle(300);
    endtask

    task automatic test_restart_and_reset();
        int vb, tb;
        pulseStart();
        applyIdle(3000);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rs_busy: got %b want 1", busy); end
        vb = validCnt; tb = timeoutCnt;
        pulseStart();
        applyIdle(3000);
        total++; if (validCnt - vb != 0) begin bad++; $display("[TB] FAIL rs_no_pulse: got %0d want 0", validCnt - vb); end
        applyStimulus(NOM, 12);
        total++; if (validCnt - vb != 1) begin bad++; $display("[TB] FAIL rs_valid: got %0d want 1", validCnt - vb); end
        checkTofWindow("rs_tof", 3000);
        total++; if (timeoutCnt - tb != 0) begin bad++; $display("[TB] FAIL rs_timeout: got %0d want 0", timeoutCnt - tb); end
        applyIdle(300);

        pulseStart();
        applyIdle(2000);
        vb = validCnt; tb = timeoutCnt;
        applyStimulus(NOM, 5);
        rstN = 1'b0;
        tick();
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL mid_rst_busy: got %b want 0", busy); end
        total++; if (tof !== '0)        begin bad++; $display("[TB] FAIL mid_rst_tof: got %0d want 0", tof); end
        total++; if (periodLast !== '0) begin bad++; $display("[TB] FAIL mid_rst_period: got %0d want 0", periodLast); end
        rstN = 1'b1;
        applyIdle(3000);
        total++; if (validCnt - vb != 0)   begin bad++; $display("[TB] FAIL mid_rst_valid: got %0d want 0", validCnt - vb); end
        total++; if (timeoutCnt - tb != 0) begin bad++; $display("[TB] FAIL mid_rst_timeout: got %0d want 0", timeoutCnt - tb); end
        total++; if (bothCnt != 0) begin bad++; $display("[TB] FAIL both_pulses: got %0d cycles want 0", bothCnt); end
    endtask

    initial begin
        $display("[TB] burst_echo_receiver directed tests");
        test_reset();
        test_basic_echo();
        test_blanking();
        test_timeout();
        test_period_qual();
        test_restart_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
